// File: rtl/sixteen_bit_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: default widths and FSM states.
package sixteen_bit_serial_subtractor_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_SLICE  = 4;
  localparam int unsigned DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sixteen_bit_serial_subtractor_slice.sv
// Four-bit lookahead slice computing a + bn + cin, with bn the pre-inverted subtrahend.
module four_bit_sub_slice (
  input  logic [3:0] a,
  input  logic [3:0] bn,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  logic       grp_p;
  logic       grp_g;

  assign p = a ^ bn;
  assign g = a & bn;

  // Every carry is expanded from cin directly so no carry ripples through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  assign cout = grp_g | (grp_p & cin);
  assign s    = p ^ c;

endmodule

// File: rtl/sixteen_bit_serial_subtractor.sv
// Multi-cycle D = A - B - Bin, one 4-bit slice per clock, LSB first, with valid/ready on both sides.
module sixteen_bit_serial_subtractor
  import sixteen_bit_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_t           state;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bn_q;
  logic             c_q;
  logic [SLICE-1:0] s;
  logic             cout;
  logic [WIDTH-1:0] d_next;
  logic             accept;

  // Operands shift right each cycle, so the active slice always sits in the low bits.
  four_bit_sub_slice u_slice (
    .a    (a_q[SLICE-1:0]),
    .bn   (bn_q[SLICE-1:0]),
    .cin  (c_q),
    .s    (s),
    .cout (cout)
  );

  always_comb begin
    d_next = D;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) d_next[i*SLICE +: SLICE] = s;
    end
  end

  // armed keeps in_ready low until the first clock after reset release.
  assign in_ready = armed & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      bn_q      <= '0;
      c_q       <= 1'b0;
      D         <= '0;
      Bout      <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: ;
        RUN: begin
          D    <= d_next;
          c_q  <= cout;
          a_q  <= a_q >> SLICE;
          bn_q <= bn_q >> SLICE;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            Bout      <= ~cout;
            // Sign bits of A and B differ exactly when A's MSB equals the inverted B's MSB.
            V         <= (a_q[SLICE-1] == bn_q[SLICE-1]) & (s[SLICE-1] != a_q[SLICE-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        a_q   <= A;
        bn_q  <= ~B;
        c_q   <= ~Bin;
        cnt   <= '0;
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_sixteen_bit_serial_subtractor.sv
// Randomized and directed bench for the serial subtractor against an arithmetic reference.
module tb_sixteen_bit_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
  logic        v;

  int n_vec;
  int n_err;
  int cyc;

  sixteen_bit_serial_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d),
    .Bout      (bout),
    .V         (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {V, Bout, D} from plain unsigned and signed integer arithmetic.
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] w;
    int          r;
    w = {1'b0, x} - {1'b0, y} - 17'(bi);
    r = int'($signed(x)) - int'($signed(y)) - int'(bi);
    return {(r < -32768) || (r > 32767), w[16], w[15:0]};
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bi, input string tag);
    int w;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    check({tag, " accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input logic [15:0] x, input logic [15:0] y, input logic bi, input string tag);
    int          k;
    logic [17:0] e;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    e = ref_sub(x, y, bi);
    check({tag, " latency"}, 32'(k), 32'd4);
    check({tag, " D"}, 32'(d), 32'(e[15:0]));
    check({tag, " Bout"}, 32'(bout), 32'(e[16]));
    check({tag, " V"}, 32'(v), 32'(e[17]));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x;
    logic [15:0] y;
    logic        bi;
    logic [17:0] e;
    int          t0;
    int          k;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    #12;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst D", 32'(d), 32'd0);
    check("rst Bout", 32'(bout), 32'd0);
    check("rst V", 32'(v), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("armed in_ready", 32'(in_ready), 32'd1);

    send(16'h1234, 16'h0234, 1'b0, "dir0"); expect_res(16'h1234, 16'h0234, 1'b0, "dir0"); handshake("dir0");
    send(16'h0000, 16'h0001, 1'b0, "dir1"); expect_res(16'h0000, 16'h0001, 1'b0, "dir1"); handshake("dir1");
    send(16'h8000, 16'h0001, 1'b0, "dir2"); expect_res(16'h8000, 16'h0001, 1'b0, "dir2"); handshake("dir2");
    send(16'h5555, 16'h5555, 1'b1, "dir3"); expect_res(16'h5555, 16'h5555, 1'b1, "dir3");
    check("dir3 D const", 32'(d), 32'h0000_FFFF);
    check("dir3 Bout const", 32'(bout), 32'd1);
    handshake("dir3");

    // Backpressure: outputs frozen and inputs ignored while out_ready is low.
    send(16'h7FFF, 16'hFFFF, 1'b0, "bp"); expect_res(16'h7FFF, 16'hFFFF, 1'b0, "bp");
    e = ref_sub(16'h7FFF, 16'hFFFF, 1'b0);
    repeat (3) begin
      @(negedge clk);
      in_valid = ~in_valid; a = 16'($urandom());
      #1;
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp D", 32'(d), 32'(e[15:0]));
      check("bp Bout", 32'(bout), 32'(e[16]));
      check("bp V", 32'(v), 32'(e[17]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    handshake("bp");

    // Back-to-back: second result five cycles after the first.
    send(16'h1234, 16'h0234, 1'b0, "b2b1"); expect_res(16'h1234, 16'h0234, 1'b0, "b2b1");
    t0 = cyc;
    out_ready = 1'b1;
    send(16'hA5A5, 16'h5A5A, 1'b1, "b2b2");
    check("b2b gap out_valid", 32'(out_valid), 32'd0);
    expect_res(16'hA5A5, 16'h5A5A, 1'b1, "b2b2");
    check("b2b spacing", 32'(cyc - t0), 32'd5);
    @(negedge clk);
    check("b2b drain", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset in the middle of RUN discards the operation.
    send(16'hABCD, 16'h0003, 1'b0, "rstrun");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst D", 32'(d), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'hFFFF, 16'h0001, 1'b0, "post");
    expect_res(16'hFFFF, 16'h0001, 1'b0, "post");
    check("post D const", 32'(d), 32'h0000_FFFE);
    handshake("post");

    // Random operands with random result hold time.
    for (int i = 0; i < 40; i++) begin
      x  = 16'($urandom());
      y  = (i % 5 == 0) ? x : 16'($urandom());
      bi = 1'($urandom());
      send(x, y, bi, "rnd");
      expect_res(x, y, bi, "rnd");
      k = int'($urandom_range(0, 2));
      repeat (k) @(negedge clk);
      check("rnd hold", 32'(out_valid), 32'd1);
      handshake("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
